// File: rtl/sum_capture_pkg.sv
// Shared types and defaults for the sum-result capture block and its FIFO.
// Entry layout is {res, co, mode}; pointer/level widths derive from DEPTH.
package sum_capture_pkg;

  localparam int DEF_N     = 16;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_CNT_W = 8;
  localparam int PTR_W     = $clog2(DEF_DEPTH);

  typedef struct packed {
    logic [DEF_N-1:0] res;
    logic             co;
    logic             mode;
  } entry_t;

  // Occupancy needs one extra bit so that "full" (== DEPTH) is representable.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sum_result_capture_if.sv
// Upstream mux result handshake plus downstream head-of-queue handshake.
// slave = capture block side, master = upstream/downstream driver side.
interface sum_result_capture_if #(
  parameter int N = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] sel_res;
  logic         sel_co;
  logic         sel;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_res;
  logic         out_co;
  logic         out_mode;

  modport slave (
    input  in_valid, sel_res, sel_co, sel, out_ready,
    output in_ready, out_valid, out_res, out_co, out_mode
  );

  modport master (
    output in_valid, sel_res, sel_co, sel, out_ready,
    input  in_ready, out_valid, out_res, out_co, out_mode
  );
endinterface

// File: rtl/sum_result_capture_sync_fifo.sv
// Generic sync FIFO: push visible one cycle later, no fall-through, no full-bypass.
// Full/empty come from registered level only; push ignored when full, pop when empty.
module sync_fifo import sum_capture_pkg::*; #(
  parameter  int W     = 18,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = lvl_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdat_i,
  output logic [W-1:0]  rdat_o,
  output logic [LW-1:0] level_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push_ok, pop_ok;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdat_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdat_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage is deliberately unreset; validity is tracked by level alone.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/sum_result_capture.sv
// Queues adder mux results; head visible 1 cycle after push, in_ready low when full.
// Counts sum-mode carry-outs (saturating, clear wins) without ever stalling.
module sum_result_capture import sum_capture_pkg::*; #(
  parameter  int N     = DEF_N,
  parameter  int DEPTH = DEF_DEPTH,
  parameter  int CNT_W = DEF_CNT_W,
  localparam int LW    = lvl_w(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sum_result_capture_if.slave  bus,
  input  logic                 clr_count,
  output logic [CNT_W-1:0]     co_count,
  output logic [LW-1:0]        level
);

  typedef struct packed {
    logic [N-1:0] res;
    logic         co;
    logic         mode;
  } cap_ent_t;

  cap_ent_t         wr_ent, rd_ent;
  logic             full, empty;
  logic             push, pop;
  logic [CNT_W-1:0] co_count_q, co_count_d;

  assign wr_ent = '{res: bus.sel_res, co: bus.sel_co, mode: bus.sel};
  assign push   = bus.in_valid && !full;
  assign pop    = bus.out_ready && !empty;

  sync_fifo #(
    .W     ($bits(cap_ent_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdat_i  (wr_ent),
    .rdat_o  (rd_ent),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_res   = empty ? '0   : rd_ent.res;
  assign bus.out_co    = empty ? 1'b0 : rd_ent.co;
  assign bus.out_mode  = empty ? 1'b0 : rd_ent.mode;

  always_comb begin
    co_count_d = co_count_q;
    if (clr_count) begin
      co_count_d = '0;
    end else if (push && bus.sel_co && !bus.sel && (co_count_q != '1)) begin
      co_count_d = co_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      co_count_q <= '0;
    end else begin
      co_count_q <= co_count_d;
    end
  end

  assign co_count = co_count_q;

endmodule

// File: tb/tb_sum_result_capture.sv
// Directed self-checking bench for sum_result_capture (N=16, DEPTH=4, CNT_W=8).
module tb_sum_result_capture;

  logic       clk;
  logic       rst_n;
  logic       clr_count;
  logic [7:0] co_count;
  logic [2:0] level;
  int         total;
  int         bad;

  sum_result_capture_if #(.N(16)) bus ();

  sum_result_capture #(.N(16), .DEPTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .clr_count (clr_count),
    .co_count  (co_count),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic co, input logic s);
    bus.in_valid = v;
    bus.sel_res  = d;
    bus.sel_co   = co;
    bus.sel      = s;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    clr_count = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_level",     32'(level),         32'd0);
    chk("rst_co_count",  32'(co_count),      32'd0);
    chk("rst_out_res",   32'(bus.out_res),   32'd0);
    rst_n = 1'b1;
    step();

    // Ordering with a stalled head
    drive(1'b1, 16'h1234, 1'b1, 1'b0);
    step();
    chk("ord_fallthru", 32'(bus.out_res), 32'h1234);
    drive(1'b1, 16'h00AB, 1'b0, 1'b1);
    step();
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    chk("ord_level2",  32'(level),         32'd2);
    chk("ord_head",    32'(bus.out_res),   32'h1234);
    chk("ord_head_co", 32'(bus.out_co),    32'd1);
    step();
    chk("ord_hold",    32'(bus.out_res),   32'h1234);
    chk("ord_cnt",     32'(co_count),      32'd1);
    bus.out_ready = 1'b1;
    step();
    chk("ord_second",  32'(bus.out_res),   32'h00AB);
    chk("ord_mode",    32'(bus.out_mode),  32'd1);
    chk("ord_level1",  32'(level),         32'd1);
    step();
    chk("ord_empty",   32'(bus.out_valid), 32'd0);
    chk("ord_res0",    32'(bus.out_res),   32'd0);
    chk("ord_cnt2",    32'(co_count),      32'd1);

    // Full: no bypass push on a same-cycle pop
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'(16'h10 + i), 1'b0, 1'b1);
      step();
    end
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("full_level",    32'(level),        32'd4);
    drive(1'b1, 16'h0099, 1'b0, 1'b1);
    bus.out_ready = 1'b1;
    step();
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    chk("full_pop_level", 32'(level),        32'd3);
    chk("full_ready_back", 32'(bus.in_ready), 32'd1);
    for (int i = 1; i < 4; i++) begin
      chk("full_drain", 32'(bus.out_res), 32'(16'h10 + i));
      step();
    end
    chk("full_drained", 32'(level), 32'd0);

    // Wrap: streaming 10 words through with the sink always ready
    for (int c = 0; c <= 10; c++) begin
      if (c < 10) drive(1'b1, 16'(c + 1), 1'b0, 1'b0);
      else        drive(1'b0, 16'h0, 1'b0, 1'b0);
      if (c >= 1) begin
        chk("wrap_valid", 32'(bus.out_valid), 32'd1);
        chk("wrap_data",  32'(bus.out_res),   32'(c));
      end
      chk("wrap_level_le1", 32'(level <= 3'd1), 32'd1);
      step();
    end
    chk("wrap_end_level", 32'(level), 32'd0);

    // Reset mid-stream with three entries queued
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'(16'h40 + i), 1'b1, 1'b0);
      step();
    end
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    chk("mid_level3", 32'(level),    32'd3);
    chk("mid_cnt4",   32'(co_count), 32'd4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_level", 32'(level),         32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_cnt",   32'(co_count),     32'd0);
    chk("mid_rst_res",   32'(bus.out_res),  32'd0);

    // Saturation and clear priority
    bus.out_ready = 1'b1;
    for (int i = 0; i < 260; i++) begin
      if (i == 100) chk("sat_mid", 32'(co_count), 32'd100);
      if (i == 255) chk("sat_255", 32'(co_count), 32'd255);
      drive(1'b1, 16'(i), 1'b1, 1'b0);
      step();
    end
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    chk("sat_hold", 32'(co_count), 32'd255);
    drive(1'b1, 16'h5555, 1'b1, 1'b0);
    clr_count = 1'b1;
    step();
    clr_count = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    chk("clr_wins", 32'(co_count), 32'd0);
    drive(1'b1, 16'h6666, 1'b1, 1'b0);
    step();
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    chk("clr_recount", 32'(co_count), 32'd1);
    step();
    step();

    // Mode filter: compare-mode carries never count
    for (int c = 0; c <= 5; c++) begin
      if (c < 5) drive(1'b1, 16'(16'h20 + c), 1'b1, 1'b1);
      else       drive(1'b0, 16'h0, 1'b0, 1'b0);
      if (c >= 1) begin
        chk("mode_tag",  32'(bus.out_mode), 32'd1);
        chk("mode_data", 32'(bus.out_res),  32'(16'h20 + c - 1));
      end
      step();
    end
    chk("mode_cnt", 32'(co_count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
